// File: rtl/fpu16_sequencer.sv
// fpu16_sequencer: request FIFO, single-issue control and response capture
// around an fpu16 datapath.
//
// Handshakes (both sides):
//   a transfer happens on a rising edge where valid && ready are both high.
//   The producer holds valid and its payload until that edge. Here,
//   reqReady depends only on registered FIFO occupancy, and the response
//   slot keeps rsp* stable while rspValid && !rspReady.
//
// Encodings (no package, widths are fixed):
//   fp16_t       [15:0]
//   fpuOp_t      [1:0]  ADD=0, SUB=1, MUL=2, DIV=3
//   condCode_t   [3:0]
//   statusFlag_t [4:0]  {NV, DZ, OF, UF, NX}
//   fpuComp_t    [2:0]  {lt, eq, gt}
module fpu16_sequencer #(
  parameter int QDEPTH      = 4,
  parameter int DIV_LATENCY = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [15:0] reqIn1,
  input  logic [15:0] reqIn2,
  input  logic [1:0]  reqOp,
  output logic [15:0] fpuIn1,
  output logic [15:0] fpuIn2,
  output logic [1:0]  op,
  output logic        start,
  input  logic [15:0] fpuOut,
  input  logic [3:0]  condCodes,
  input  logic [4:0]  statusFlags,
  input  logic [2:0]  comps,
  input  logic        fpuDone,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [15:0] rspOut,
  output logic [3:0]  rspCondCodes,
  output logic [4:0]  rspFlags,
  output logic [2:0]  rspComps,
  output logic [4:0]  stickyFlags,
  input  logic        clearSticky,
  output logic        busy
);

  localparam int AW = $clog2(QDEPTH);
  // Counter only has to reach DIV_LATENCY-1; it saturates for long MULs.
  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [AW:0]   FULL     = (AW + 1)'(QDEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_LATENCY - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  state_t          state_q, state_d;

  logic [15:0]     fifo_in1_q [QDEPTH];
  logic [15:0]     fifo_in2_q [QDEPTH];
  logic [1:0]      fifo_op_q  [QDEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;

  logic [15:0]     in1_q, in2_q;
  logic [1:0]      op_q;
  logic [CW-1:0]   cnt_q;

  logic            rsp_valid_q;
  logic [15:0]     rsp_out_q;
  logic [3:0]      rsp_cc_q;
  logic [4:0]      rsp_flags_q;
  logic [2:0]      rsp_comps_q;
  logic [4:0]      sticky_q, sticky_d;

  logic            push, issue, capture, exec_done;

  assign reqReady = reset && (count_q != FULL);
  assign push     = reqValid && reqReady;

  // Output decode: issue/capture decisions and the start pulse.
  always_comb begin
    issue     = 1'b0;
    exec_done = 1'b0;
    start     = 1'b0;
    if (state_q == S_IDLE) begin
      issue = (count_q != '0) && (!rsp_valid_q || rspReady);
    end else begin
      start = (cnt_q == '0);
      case (op_q)
        OP_ADD, OP_SUB: exec_done = 1'b1;
        OP_MUL:         exec_done = fpuDone;
        OP_DIV:         exec_done = (cnt_q == DIV_LAST);
        default:        exec_done = 1'b0;
      endcase
    end
    capture = (state_q == S_EXEC) && exec_done;
  end

  // Next-state logic: IDLE waits for work and a free slot, EXEC for completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue)   state_d = S_EXEC;
      S_EXEC:  if (capture) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FIFO occupancy and sticky next values; a clear lands before the OR.
  always_comb begin
    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    sticky_d = (clearSticky ? 5'b0 : sticky_q) | (capture ? statusFlags : 5'b0);
  end

  // FIFO pointers and count; emptying the FIFO only needs these cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage, written at the tail on every accepted request.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_in1_q[wr_ptr_q] <= reqIn1;
      fifo_in2_q[wr_ptr_q] <= reqIn2;
      fifo_op_q[wr_ptr_q]  <= reqOp;
    end
  end

  // Operands held toward fpu16 from one issue to the next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= OP_ADD;
    end else if (issue) begin
      in1_q <= fifo_in1_q[rd_ptr_q];
      in2_q <= fifo_in2_q[rd_ptr_q];
      op_q  <= fifo_op_q[rd_ptr_q];
    end
  end

  // EXEC cycle counter: cleared on issue, counts up and saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= '0;
    end else if ((state_q == S_EXEC) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response slot: filled on capture, emptied when the consumer takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_cc_q    <= '0;
      rsp_flags_q <= '0;
      rsp_comps_q <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_out_q   <= fpuOut;
      rsp_cc_q    <= condCodes;
      rsp_flags_q <= statusFlags;
      rsp_comps_q <= comps;
    end else if (rspReady) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Sticky exception flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign fpuIn1       = in1_q;
  assign fpuIn2       = in2_q;
  assign op           = op_q;
  assign rspValid     = rsp_valid_q;
  assign rspOut       = rsp_out_q;
  assign rspCondCodes = rsp_cc_q;
  assign rspFlags     = rsp_flags_q;
  assign rspComps     = rsp_comps_q;
  assign stickyFlags  = sticky_q;
  assign busy         = (count_q != '0) || (state_q != S_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_fpu16_sequencer.sv
// Testbench for fpu16_sequencer. The fpu16 datapath is replaced by a
// behavioural stub; expected responses are computed from each accepted
// request and queued in request order.
module tb_fpu16_sequencer;

  localparam int QDEPTH      = 4;
  localparam int DIV_LATENCY = 12;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam int W = 28;

  logic        clock, reset;
  logic        reqValid, reqReady;
  logic [15:0] reqIn1, reqIn2;
  logic [1:0]  reqOp;
  logic [15:0] fpuIn1, fpuIn2;
  logic [1:0]  op;
  logic        start;
  logic [15:0] fpuOut;
  logic [3:0]  condCodes;
  logic [4:0]  statusFlags;
  logic [2:0]  comps;
  logic        fpuDone;
  logic        rspValid, rspReady;
  logic [15:0] rspOut;
  logic [3:0]  rspCondCodes;
  logic [4:0]  rspFlags;
  logic [2:0]  rspComps;
  logic [4:0]  stickyFlags;
  logic        clearSticky;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int mul_delay = 3;     // cycles from start to fpuDone; -1 picks at random
  bit rand_bg = 0;

  fpu16_sequencer #(.QDEPTH(QDEPTH), .DIV_LATENCY(DIV_LATENCY)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqIn1(reqIn1), .reqIn2(reqIn2), .reqOp(reqOp),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .op(op), .start(start),
    .fpuOut(fpuOut), .condCodes(condCodes), .statusFlags(statusFlags),
    .comps(comps), .fpuDone(fpuDone),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspOut(rspOut), .rspCondCodes(rspCondCodes), .rspFlags(rspFlags),
    .rspComps(rspComps), .stickyFlags(stickyFlags),
    .clearSticky(clearSticky), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- fpu16 stub / reference ----------------
  function automatic logic is_nan(input logic [15:0] a);
    return (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
  endfunction

  function automatic logic [4:0] f_flags(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic nv, dz;
    nv = is_nan(a) || is_nan(b) || ((o == OP_DIV) && (a[14:0] == 0) && (b[14:0] == 0));
    dz = (o == OP_DIV) && !nv && (b[14:0] == 0);
    return {nv, dz, a[2:0] & b[2:0]};
  endfunction

  function automatic logic [15:0] f_res(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [4:0] fl;
    fl = f_flags(o, a, b);
    if (fl[4]) return 16'h7E00;
    if (fl[3]) return {a[15] ^ b[15], 15'h7C00};
    if (o == OP_ADD && a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
    if (o == OP_MUL && a == 16'h4000 && b == 16'h4200) return 16'h4600;
    return a ^ {b[7:0], b[15:8]} ^ {o, 14'h0101};
  endfunction

  function automatic logic [3:0] f_cc(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = f_res(o, a, b);
    return {r[15], r[14:0] == 0, is_nan(r), r[0]};
  endfunction

  function automatic logic [2:0] f_comps(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 3'b000;
    return {a < b, a == b, a > b};
  endfunction

  function automatic logic [W-1:0] f_rsp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    return {f_res(o, a, b), f_cc(o, a, b), f_flags(o, a, b), f_comps(a, b)};
  endfunction

  assign fpuOut      = f_res(op, fpuIn1, fpuIn2);
  assign condCodes   = f_cc(op, fpuIn1, fpuIn2);
  assign statusFlags = f_flags(op, fpuIn1, fpuIn2);
  assign comps       = f_comps(fpuIn1, fpuIn2);

  // Multiplier done strobe: a counter armed when a MUL start is seen.
  // It deliberately ignores reset so a late strobe can follow a reset.
  initial begin : mul_done_gen
    int mul_cnt;
    mul_cnt = -1;
    fpuDone = 1'b0;
    forever begin
      @(negedge clock);
      fpuDone = 1'b0;
      if (start && op == OP_MUL)
        mul_cnt = (mul_delay < 0) ? int'($urandom_range(0, 4)) : mul_delay;
      else if (mul_cnt > 0)
        mul_cnt--;
      if (mul_cnt == 0) begin
        fpuDone = 1'b1;
        mul_cnt = -1;
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic         prev_valid;
    logic [W-1:0] prev_rsp, got, e;
    logic         rdy, clr;
    logic [4:0]   exp_sticky;
    prev_valid = 1'b0;
    prev_rsp   = '0;
    exp_sticky = '0;
    forever begin
      @(posedge clock);
      rdy = rspReady;
      clr = clearSticky;
      #1;
      if (!reset) begin
        prev_valid = 1'b0;
        exp_sticky = '0;
        continue;
      end
      got = {rspOut, rspCondCodes, rspFlags, rspComps};
      if (clr) exp_sticky = '0;
      if (prev_valid && !rdy) begin
        check("rsp_hold", {35'b0, rspValid, got}, {35'b0, 1'b1, prev_rsp});
      end else if (rspValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %h expected none (t=%0t)", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {36'b0, got}, {36'b0, e});
          exp_sticky = exp_sticky | e[7:3];
        end
      end
      check("sticky", {59'b0, stickyFlags}, {59'b0, exp_sticky});
      prev_valid = rspValid;
      prev_rsp   = got;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int   n;
    logic rdy;
    @(negedge clock);
    reqValid = 1'b1;
    reqOp    = o;
    reqIn1   = a;
    reqIn2   = b;
    n = 0;
    forever begin
      rdy = reqReady;
      @(posedge clock);
      if (rdy) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept in %0d cycles expected accept", n);
        break;
      end
      @(negedge clock);
    end
    if (rdy) exp_q.push_back(f_rsp(o, a, b));
    @(negedge clock);
    reqValid = 1'b0;
  endtask

  // Counts edges from the current point until rspValid is seen (-1 on timeout).
  task automatic measure(input int budget, input bit chk_ops, input logic [1:0] o,
                         input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int starts);
    int n;
    starts = 0;
    lat = -1;
    n = 0;
    while (n < budget) begin
      @(posedge clock);
      #1;
      n++;
      if (start) starts++;
      if (chk_ops) check("exec_operands", {30'b0, fpuIn1, fpuIn2, op}, {30'b0, a, b, o});
      if (rspValid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Random consumer backpressure and sticky clears.
  initial begin : bg_driver
    forever begin
      @(negedge clock);
      if (rand_bg) begin
        rspReady    = ($urandom_range(0, 9) < 7);
        clearSticky = ($urandom_range(0, 19) == 0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, starts;
    logic [15:0] a, b;
    logic [1:0]  o;
    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    bp_a = '{16'h3C01, 16'h4003, 16'h1235, 16'hC007, 16'h0F0F};
    bp_b = '{16'h3C03, 16'h2007, 16'h7001, 16'h4006, 16'h00FF};

    reset = 1'b0;
    reqValid = 1'b0;
    reqIn1 = '0;
    reqIn2 = '0;
    reqOp = OP_ADD;
    rspReady = 1'b1;
    clearSticky = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_ctl", {26'b0, reqReady, start, rspValid, busy, op, fpuIn1, fpuIn2}, 64'h0);
    check("reset_rsp", {31'b0, rspOut, rspCondCodes, rspFlags, rspComps, stickyFlags}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_reset", {63'b0, reqReady}, 64'h1);

    // Single ADD: latency 2, one-cycle start
    send(OP_ADD, 16'h3C00, 16'h3C00);
    measure(20, 1'b0, OP_ADD, 16'h0, 16'h0, lat, starts);
    check("add_latency", lat, 2);
    check("add_start_cycles", starts, 1);
    check("add_result", {48'b0, rspOut}, 64'h4000);
    check("add_flags", {59'b0, rspFlags}, 64'h0);
    wait_idle();

    // MUL with done 3 cycles after start; operands stable through EXEC
    mul_delay = 3;
    send(OP_MUL, 16'h4000, 16'h4200);
    measure(40, 1'b1, OP_MUL, 16'h4000, 16'h4200, lat, starts);
    check("mul_latency", lat, 5);
    check("mul_result", {48'b0, rspOut}, 64'h4600);
    wait_idle();

    // Backpressure: first result held, FIFO fills, then drains in order
    @(negedge clock);
    rspReady = 1'b0;
    for (int i = 0; i < 5; i++) send(OP_ADD, bp_a[i], bp_b[i]);
    repeat (3) @(negedge clock);
    check("bp_full", {61'b0, reqReady, rspValid, busy}, 64'b011);
    check("bp_held_out", {48'b0, rspOut}, {48'b0, f_res(OP_ADD, bp_a[0], bp_b[0])});
    @(negedge clock);
    rspReady = 1'b1;
    wait_idle();
    check("bp_drained", exp_q.size(), 0);

    // DIV by zero: latency DIV_LATENCY+1, DZ sticky
    send(OP_DIV, 16'h3C00, 16'h0000);
    measure(60, 1'b1, OP_DIV, 16'h3C00, 16'h0000, lat, starts);
    check("div_latency", lat, DIV_LATENCY + 1);
    check("div_sticky_dz", {63'b0, stickyFlags[3]}, 64'h1);
    wait_idle();

    // Clear on the capture edge of a NaN ADD leaves NV only
    send(OP_ADD, 16'h7E00, 16'h3C00);
    @(negedge clock);
    clearSticky = 1'b1;
    @(posedge clock);
    #1;
    check("clear_on_capture", {59'b0, stickyFlags}, 64'h10);
    @(negedge clock);
    clearSticky = 1'b0;
    wait_idle();

    // Sticky accumulation: NV survives clean ADDs
    send(OP_ADD, 16'h3C00, 16'h4000);
    send(OP_ADD, 16'h4400, 16'h3800);
    send(OP_ADD, 16'h4200, 16'h4200);
    wait_idle();
    check("sticky_accum", {59'b0, stickyFlags}, 64'h10);
    check("last_add_flags", {59'b0, rspFlags}, 64'h0);

    // Reset in the middle of a MUL with requests queued
    mul_delay = 10;
    send(OP_MUL, 16'h4400, 16'h4400);
    send(OP_ADD, 16'h3C00, 16'h3C00);
    send(OP_SUB, 16'h4000, 16'h3C00);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_ctl", {26'b0, reqReady, start, rspValid, busy, op, fpuIn1, fpuIn2}, 64'h0);
    check("midrst_rsp", {31'b0, rspOut, rspCondCodes, rspFlags, rspComps, stickyFlags}, 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    check("late_done_ignored", {62'b0, rspValid, busy}, 64'h0);
    mul_delay = -1;
    send(OP_ADD, 16'h3C00, 16'h3C00);
    measure(20, 1'b0, OP_ADD, 16'h0, 16'h0, lat, starts);
    check("post_reset_add_latency", lat, 2);
    wait_idle();

    // Randomized traffic with random backpressure and clears
    rand_bg = 1;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = {a[15], 5'h1F, 1'b1, a[8:0]};
      if ($urandom_range(0, 7) == 0) b = {b[15], 15'h0};
      send(o, a, b);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    rand_bg = 0;
    @(negedge clock);
    rspReady = 1'b1;
    clearSticky = 1'b0;
    wait_idle();
    repeat (2) @(negedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
